// File: rtl/jts16_dbg_pkg.sv
// Shared definitions for the palette dump reader: state encoding and palette size.
package jts16_dbg_pkg;

   localparam int unsigned PAL_AW = 11;

   typedef enum logic [2:0] {
      StIdle,
      StWaitVb,
      StRead,
      StCapt,
      StTxLo,
      StTxHi,
      StFin
   } dump_state_e;

endpackage

// File: rtl/jts16_byte_ser.sv
// Holds one 16-bit word and presents it as two bytes, low byte first, on a
// valid/ready stream. Signals o_sent on the cycle the high byte is accepted.
module jts16_byte_ser (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [15:0] i_word,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_sent
);

   logic [15:0] r_word;
   logic        r_valid;
   logic        r_hi;
   logic        w_hs;

   assign w_hs = r_valid & i_ready;

   // Word register and byte phase; data stays stable until each byte is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word  <= '0;
         r_valid <= 1'b0;
         r_hi    <= 1'b0;
      end else if (i_load) begin
         r_word  <= i_word;
         r_valid <= 1'b1;
         r_hi    <= 1'b0;
      end else if (w_hs) begin
         if (r_hi) begin
            r_valid <= 1'b0;
            r_hi    <= 1'b0;
         end else begin
            r_hi <= 1'b1;
         end
      end
   end

   assign o_data  = r_hi ? r_word[15:8] : r_word[7:0];
   assign o_valid = r_valid;
   assign o_sent  = w_hs & r_hi;

endmodule

// File: rtl/jts16_pal_dump.sv
// Palette dump reader: walks every palette word during vertical blank, streams
// each word as two bytes and keeps a 16-bit running sum of the words read.
module jts16_pal_dump
   import jts16_dbg_pkg::*;
#(
   parameter int unsigned AW     = PAL_AW,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          LVBL,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          dump_en,
   output logic [AW-1:0] dump_addr,
   input  logic [15:0]   dump_dout,
   output logic [7:0]    st_data,
   output logic          st_valid,
   input  logic          st_ready,
   output logic [15:0]   checksum
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   dump_state_e   r_state;
   dump_state_e   w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [15:0]   r_sum;
   logic [1:0]    r_lat;

   logic w_load;
   logic w_sent;
   logic w_hs;
   logic w_last;
   logic w_lat_done;
   logic w_clr;
   logic w_inc;

   assign w_hs       = st_valid & st_ready;
   assign w_last     = (r_addr == {AW{1'b1}});
   assign w_lat_done = (r_lat == LAT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      done        = 1'b0;
      dump_en     = 1'b0;
      w_load      = 1'b0;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      unique case (r_state)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               w_clr       = 1'b1;
               w_state_nxt = StWaitVb;
            end
         end
         StWaitVb: begin
            if (!LVBL) w_state_nxt = StRead;
         end
         StRead: begin
            dump_en = 1'b1;
            if (w_lat_done) w_state_nxt = StCapt;
         end
         StCapt: begin
            dump_en     = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = StTxLo;
         end
         StTxLo: begin
            if (w_hs) w_state_nxt = StTxHi;
         end
         StTxHi: begin
            if (w_sent) begin
               if (w_last) begin
                  w_state_nxt = StFin;
               end else begin
                  w_inc = 1'b1;
                  // Blanking check folded in here so a word costs RD_LAT+3 cycles
                  // when LVBL stays low; otherwise park in WAITVB.
                  w_state_nxt = LVBL ? StWaitVb : StRead;
               end
            end
         end
         StFin: begin
            busy        = 1'b0;
            done        = 1'b1;
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Read latency counter: counts cycles spent in READ.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat <= '0;
      end else if (r_state == StRead && !w_lat_done) begin
         r_lat <= r_lat + 2'd1;
      end else begin
         r_lat <= '0;
      end
   end

   // Word address counter and running checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= '0;
         r_sum  <= '0;
      end else begin
         if (w_clr) begin
            r_addr <= '0;
            r_sum  <= '0;
         end else begin
            if (w_inc) r_addr <= r_addr + AW'(1);
            if (w_load) r_sum <= r_sum + dump_dout;
         end
      end
   end

   assign dump_addr = r_addr;
   assign checksum  = r_sum;

   jts16_byte_ser u_ser (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (w_load),
      .i_word  (dump_dout),
      .o_data  (st_data),
      .o_valid (st_valid),
      .i_ready (st_ready),
      .o_sent  (w_sent)
   );

endmodule

// File: doc/jts16_pal_dump.md
Name: jts16_pal_dump

Overview:
- Reader at the far end of the colour mixer's palette dump port (dump_en / dump_addr / dump_dout).
- On request, scans all palette words in order, only during vertical blank, so the video read port is never stolen during active lines.
- Serialises each 16-bit word into a byte stream with a valid/ready handshake for the debug/save-state path.
- Keeps a running 16-bit word sum for integrity checks.

Parameters:
- AW, 11, palette address width; word count = 2**AW.
- RD_LAT, 1, palette RAM read latency in clk cycles, counted from the address cycle to valid dump_dout (1..3).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- LVBL  input  1  vertical blank, active low; reads start only while LVBL=0.
- start  input  1  one-cycle pulse that begins a dump; ignored while busy=1.
- busy  output  1  high from start acceptance until the last byte is accepted.
- done  output  1  one-cycle pulse after the last byte handshake.
- dump_en  output  1  steals the palette video read port.
- dump_addr  output  AW  palette word address.
- dump_dout  input  16  palette word from RAM.
- st_data  output  8  stream byte.
- st_valid  output  1  st_data is valid.
- st_ready  input  1  sink accepts; a byte transfers when st_valid & st_ready at a clk edge.
- checksum  output  16  running sum (mod 2^16) of words read; valid when done pulses.

Behaviour:
- Reset values: busy=0, done=0, dump_en=0, dump_addr=0, st_valid=0, st_data=0, checksum=0, state=IDLE, word counter=0.
- Reset mid-dump: abort immediately; dump_en drops on the next edge; no done pulse.
- State IDLE:
  - start=1 -> WAITVB; clear the address counter and checksum; busy=1.
- State WAITVB:
  - dump_en=0.
  - LVBL=0 -> READ.
  - Otherwise stay.
- State READ:
  - dump_en=1 with dump_addr=counter, held for RD_LAT cycles.
  - Then go to CAPT; dump_en stays 1.
- State CAPT:
  - dump_en=1.
  - Latch dump_dout into the word register.
  - checksum += word.
  - -> TXLO.
  - Once READ is entered, the read completes even if LVBL rises: at most RD_LAT+1 cycles of overrun into active video. This is accepted.
- State TXLO:
  - dump_en=0; st_valid=1; st_data=word[7:0].
  - Stay until st_ready=1, then -> TXHI.
- State TXHI:
  - st_data=word[15:8].
  - On handshake:
    - if counter == 2**AW-1 -> FIN;
    - else counter+1 -> WAITVB.
  - Every word re-checks LVBL before its read, so a dump spanning several frames pauses outside vblank.
- State FIN:
  - st_valid=0; done=1 for exactly one cycle; busy=0 in the same cycle.
  - -> IDLE.
- Handshake rules:
  - st_valid, once high, stays high with st_data stable until accepted.
  - st_ready may be held high permanently: then each word costs RD_LAT+3 cycles (READ…TXHI) when LVBL stays low.
- Byte order: low byte first, then high byte; 2·2**AW bytes in total.
- Counter wrap: the counter never wraps within a dump; the last word is address 2**AW-1.
- Simultaneous events:
  - start coinciding with FIN is ignored; start must come again from IDLE.
  - start with LVBL=0 goes to READ one cycle later, through WAITVB.
- checksum is held after done until the next accepted start clears it.

Decomposition:
- Shared package jts16_dbg_pkg:
  - state encoding enum (IDLE, WAITVB, READ, CAPT, TXLO, TXHI, FIN);
  - PAL_AW=11 constant.
- One sub-module, jts16_byte_ser: takes a 16-bit word with load/valid, emits low then high byte over the valid/ready handshake, and reports "word sent". The top level keeps the FSM, counter, checksum and dump-port drive.

Test Plan:
- Preload RAM words[i]=i*0x0101 (AW=11), LVBL held 0, st_ready=1, start pulse -> 4096 bytes: 00,00,01,01,… ; done after 2048×4 cycles ±2; checksum=0x0400*(2047)… compare against the bench model sum mod 2^16.
- LVBL=1 at start, dropping 100 cycles later -> dump_en stays 0 and no bytes appear until LVBL falls; first dump_en one cycle after the fall.
- LVBL rises while in READ at addr 0x123 -> the read completes; word 0x123 is captured correctly; dump_en drops after CAPT; addr 0x124 is not read until the next LVBL=0.
- st_ready toggled randomly 30% -> st_data is stable while st_valid & !st_ready; byte count is exactly 4096; no duplicates or drops.
- rst asserted at word 0x400 during TXHI -> next cycle: dump_en=0, st_valid=0, busy=0, checksum=0; no done pulse; a fresh start restarts at addr 0.
- start pulsed while busy at word 5 -> ignored; the sequence and checksum are unchanged versus a run without the extra pulse.
